// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline hold/flush control for the 5-stage core.
// Covers load-use bubbles, branch/trap flushes, memory stalls and CSR serialization.
//
// Ports:
//   clk, reset              clock, async active-low reset
//   id_rs1_addr/rs2_addr    ID-stage source registers
//   id_is_csr               ID-stage CSR access
//   exe_memread/rd_addr     EXE-stage load and destination
//   branch_taken            taken branch/jump resolved in EXE
//   trap_redirect           trap or mret redirect
//   im_busy, dm_busy        instruction/data memory not ready
//   pc_hold, ifid_hold      hold PC and IF/ID
//   ifid_flush              bubble into IF/ID
//   pipe_hold               hold ID/EXE and later (memory stall)
//   idexe_flush             bubble into ID/EXE
//   csr_busy                CSR serialization in progress
//   stall_cycles            saturating count of pc_hold cycles
module pipe_hazard_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs1_addr,
  input  logic [4:0]  id_rs2_addr,
  input  logic        id_is_csr,
  input  logic        exe_memread,
  input  logic [4:0]  exe_rd_addr,
  input  logic        branch_taken,
  input  logic        trap_redirect,
  input  logic        im_busy,
  input  logic        dm_busy,
  output logic        pc_hold,
  output logic        ifid_hold,
  output logic        ifid_flush,
  output logic        pipe_hold,
  output logic        idexe_flush,
  output logic        csr_busy,
  output logic [15:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    CSR_DRAIN = 2'd1,
    CSR_ISSUE = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [1:0] cnt;
  logic [1:0] cnt_nxt;
  logic       mem_stall;
  logic       load_use;
  logic       redirect;

  assign mem_stall = im_busy | dm_busy;
  assign redirect  = trap_redirect | branch_taken;

  assign load_use = exe_memread
                  & (exe_rd_addr != 5'd0)
                  & ((exe_rd_addr == id_rs1_addr)
                   | (exe_rd_addr == id_rs2_addr));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      cnt   <= 2'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    ifid_flush  = 1'b0;
    pipe_hold   = 1'b0;
    idexe_flush = 1'b0;
    csr_busy    = (state != RUN);

    if (mem_stall) begin
      pc_hold   = 1'b1;
      ifid_hold = 1'b1;
      pipe_hold = 1'b1;
    end else if (redirect) begin
      // The redirect flushes whatever sits in ID, including a
      // CSR under serialization, so serialization is abandoned.
      ifid_flush  = 1'b1;
      idexe_flush = 1'b1;
      state_nxt   = RUN;
      cnt_nxt     = 2'd0;
    end else begin
      unique case (state)
        RUN: begin
          if (load_use) begin
            pc_hold     = 1'b1;
            ifid_hold   = 1'b1;
            idexe_flush = 1'b1;
          end else if (id_is_csr) begin
            pc_hold     = 1'b1;
            ifid_hold   = 1'b1;
            idexe_flush = 1'b1;
            state_nxt   = CSR_DRAIN;
            cnt_nxt     = 2'd2;
          end
        end
        CSR_DRAIN: begin
          pc_hold     = 1'b1;
          ifid_hold   = 1'b1;
          idexe_flush = 1'b1;
          // Entry bubble plus two drain bubbles; issue once
          // the counter reaches zero.
          if (cnt <= 2'd1) begin
            state_nxt = CSR_ISSUE;
            cnt_nxt   = 2'd0;
          end else begin
            cnt_nxt = cnt - 2'd1;
          end
        end
        CSR_ISSUE: begin
          state_nxt = RUN;
        end
        default: begin
          state_nxt = RUN;
          cnt_nxt   = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles <= 16'd0;
    end else if (pc_hold && (stall_cycles != 16'hFFFF)) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed and random checks of pipe_hazard_ctrl
// against a bubble-count reference model.
module tb_pipe_hazard_ctrl;

  logic        clk;
  logic        reset;
  logic [4:0]  id_rs1_addr;
  logic [4:0]  id_rs2_addr;
  logic        id_is_csr;
  logic        exe_memread;
  logic [4:0]  exe_rd_addr;
  logic        branch_taken;
  logic        trap_redirect;
  logic        im_busy;
  logic        dm_busy;
  logic        pc_hold;
  logic        ifid_hold;
  logic        ifid_flush;
  logic        pipe_hold;
  logic        idexe_flush;
  logic        csr_busy;
  logic [15:0] stall_cycles;

  int total;
  int bad;

  pipe_hazard_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .id_rs1_addr  (id_rs1_addr),
    .id_rs2_addr  (id_rs2_addr),
    .id_is_csr    (id_is_csr),
    .exe_memread  (exe_memread),
    .exe_rd_addr  (exe_rd_addr),
    .branch_taken (branch_taken),
    .trap_redirect(trap_redirect),
    .im_busy      (im_busy),
    .dm_busy      (dm_busy),
    .pc_hold      (pc_hold),
    .ifid_hold    (ifid_hold),
    .ifid_flush   (ifid_flush),
    .pipe_hold    (pipe_hold),
    .idexe_flush  (idexe_flush),
    .csr_busy     (csr_busy),
    .stall_cycles (stall_cycles)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // {pc_hold, ifid_hold, ifid_flush, pipe_hold, idexe_flush, csr_busy}
  logic [5:0] outs;
  assign outs = {pc_hold, ifid_hold, ifid_flush,
                 pipe_hold, idexe_flush, csr_busy};

  // Reference model: bubbles still owed to a CSR drain, and whether
  // the CSR is in its issue cycle.
  int m_drain;
  bit m_issue;
  int m_stalls;
  logic m_lu;
  logic [5:0] m_exp;

  assign m_lu = exe_memread && (exe_rd_addr != 5'd0) &&
                ((exe_rd_addr == id_rs1_addr) ||
                 (exe_rd_addr == id_rs2_addr));

  function automatic logic [5:0] m_out(
    int dr, bit is, logic mb, logic lu,
    logic rd, logic csr);
    logic busy;
    busy = (dr > 0) || is;
    if (mb)      return {5'b11010, busy};
    if (rd)      return {5'b00101, busy};
    if (dr > 0)  return 6'b110011;
    if (is)      return 6'b000001;
    if (lu)      return 6'b110010;
    if (csr)     return 6'b110010;
    return 6'b000000;
  endfunction

  assign m_exp = m_out(m_drain, m_issue, im_busy | dm_busy, m_lu,
                       trap_redirect | branch_taken, id_is_csr);

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_drain  <= 0;
      m_issue  <= 1'b0;
      m_stalls <= 0;
    end else begin
      if (!(im_busy | dm_busy)) begin
        if (trap_redirect | branch_taken) begin
          m_drain <= 0;
          m_issue <= 1'b0;
        end else if (m_drain > 0) begin
          m_drain <= m_drain - 1;
          if (m_drain == 1) m_issue <= 1'b1;
        end else if (m_issue) begin
          m_issue <= 1'b0;
        end else if (!m_lu && id_is_csr) begin
          m_drain <= 2;
        end
      end
      if (m_exp[5] && m_stalls < 65535) m_stalls <= m_stalls + 1;
    end
  end

  task automatic clr_inputs();
    id_rs1_addr   = 5'd0;
    id_rs2_addr   = 5'd0;
    id_is_csr     = 1'b0;
    exe_memread   = 1'b0;
    exe_rd_addr   = 5'd0;
    branch_taken  = 1'b0;
    trap_redirect = 1'b0;
    im_busy       = 1'b0;
    dm_busy       = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr_inputs();
    reset = 1'b0;
    cyc();
    #2 reset = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    clr_inputs();
    reset = 1'b0;
    #12;
    total++;
    if (outs !== 6'b0 || stall_cycles !== 16'd0) begin
      $display("FAIL reset_state outs=%b stall=%0d want 0/0",
               outs, stall_cycles);
      bad++;
    end
    cyc();
    #2 reset = 1'b1;
    #1;
    total++;
    if (outs !== 6'b0) begin
      $display("FAIL reset_release outs=%b want 000000", outs);
      bad++;
    end
    cyc();
  endtask

  task automatic test_load_use();
    do_reset();
    exe_memread = 1'b1;
    exe_rd_addr = 5'd5;
    id_rs2_addr = 5'd5;
    #4;
    total++;
    if (outs !== 6'b110010) begin
      $display("FAIL load_use outs=%b want 110010", outs);
      bad++;
    end
    cyc();
    clr_inputs();
    #4;
    total++;
    if (outs !== 6'b0 || stall_cycles !== 16'd1) begin
      $display("FAIL load_use_after outs=%b stall=%0d want 0/1",
               outs, stall_cycles);
      bad++;
    end
    exe_memread = 1'b1;
    exe_rd_addr = 5'd0;
    id_rs2_addr = 5'd0;
    #1;
    total++;
    if (outs !== 6'b0) begin
      $display("FAIL load_use_x0 outs=%b want 000000", outs);
      bad++;
    end
    cyc();
    clr_inputs();
    total++;
    if (stall_cycles !== 16'd1) begin
      $display("FAIL load_use_x0_stall got=%0d want 1",
               stall_cycles);
      bad++;
    end
  endtask

  task automatic test_csr();
    logic [5:0] exp [5];
    exp = '{6'b110010, 6'b110011, 6'b110011,
            6'b000001, 6'b000000};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      id_is_csr = (i < 4);
      #4;
      total++;
      if (outs !== exp[i]) begin
        $display("FAIL csr_seq[%0d] outs=%b want %b",
                 i, outs, exp[i]);
        bad++;
      end
      cyc();
    end
    clr_inputs();
    total++;
    if (stall_cycles !== 16'd3) begin
      $display("FAIL csr_stall got=%0d want 3", stall_cycles);
      bad++;
    end
  endtask

  task automatic test_mem_stall_drain();
    logic [5:0] exp [9];
    exp = '{6'b110010, 6'b110101, 6'b110101, 6'b110101,
            6'b110101, 6'b110011, 6'b110011, 6'b000001,
            6'b000000};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      id_is_csr = (i < 8);
      dm_busy   = (i >= 1 && i <= 4);
      #4;
      total++;
      if (outs !== exp[i]) begin
        $display("FAIL mem_drain[%0d] outs=%b want %b",
                 i, outs, exp[i]);
        bad++;
      end
      cyc();
    end
    clr_inputs();
    total++;
    if (stall_cycles !== 16'd7) begin
      $display("FAIL mem_drain_stall got=%0d want 7",
               stall_cycles);
      bad++;
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    branch_taken = 1'b1;
    exe_memread  = 1'b1;
    exe_rd_addr  = 5'd5;
    id_rs1_addr  = 5'd5;
    id_is_csr    = 1'b1;
    #4;
    total++;
    if (outs !== 6'b001010) begin
      $display("FAIL branch_prio outs=%b want 001010", outs);
      bad++;
    end
    cyc();
    clr_inputs();
    #4;
    total++;
    if (outs !== 6'b0 || stall_cycles !== 16'd0) begin
      $display("FAIL branch_after outs=%b stall=%0d want 0/0",
               outs, stall_cycles);
      bad++;
    end
    id_is_csr = 1'b1;
    cyc();
    trap_redirect = 1'b1;
    branch_taken  = 1'b1;
    #4;
    total++;
    if (outs !== 6'b001011) begin
      $display("FAIL trap_drain outs=%b want 001011", outs);
      bad++;
    end
    cyc();
    clr_inputs();
    #4;
    total++;
    if (outs !== 6'b0) begin
      $display("FAIL trap_after outs=%b want 000000", outs);
      bad++;
    end
    cyc();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 800; i++) begin
      id_rs1_addr   = 5'($urandom_range(0, 3));
      id_rs2_addr   = 5'($urandom_range(0, 3));
      exe_rd_addr   = 5'($urandom_range(0, 3));
      exe_memread   = ($urandom_range(0, 2) == 0);
      id_is_csr     = ($urandom_range(0, 3) == 0);
      branch_taken  = ($urandom_range(0, 9) == 0);
      trap_redirect = ($urandom_range(0, 19) == 0);
      im_busy       = ($urandom_range(0, 11) == 0);
      dm_busy       = ($urandom_range(0, 11) == 0);
      #4;
      total++;
      if (outs !== m_exp ||
          stall_cycles !== 16'(m_stalls)) begin
        $display("FAIL random[%0d] outs=%b stall=%0d want %b/%0d",
                 i, outs, stall_cycles, m_exp, m_stalls);
        bad++;
      end
      cyc();
    end
    clr_inputs();
  endtask

  task automatic test_saturation();
    do_reset();
    im_busy = 1'b1;
    repeat (70000) cyc();
    total++;
    if (stall_cycles !== 16'hFFFF || !pc_hold) begin
      $display("FAIL saturate stall=%h pc_hold=%b want ffff/1",
               stall_cycles, pc_hold);
      bad++;
    end
    cyc();
    total++;
    if (stall_cycles !== 16'hFFFF) begin
      $display("FAIL no_wrap stall=%h want ffff", stall_cycles);
      bad++;
    end
    clr_inputs();
  endtask

  task automatic test_async_reset();
    do_reset();
    id_is_csr = 1'b1;
    cyc();
    #2;
    total++;
    if (csr_busy !== 1'b1 || stall_cycles !== 16'd1) begin
      $display("FAIL pre_reset busy=%b stall=%0d want 1/1",
               csr_busy, stall_cycles);
      bad++;
    end
    clr_inputs();
    reset = 1'b0;
    #1;
    total++;
    if (outs !== 6'b0 || stall_cycles !== 16'd0) begin
      $display("FAIL async_reset outs=%b stall=%0d want 0/0",
               outs, stall_cycles);
      bad++;
    end
    cyc();
    #2 reset = 1'b1;
    #1;
    total++;
    if (outs !== 6'b0) begin
      $display("FAIL release_glitch outs=%b want 000000", outs);
      bad++;
    end
    cyc();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_load_use();
    test_csr();
    test_mem_stall_drain();
    test_simultaneous();
    test_random();
    test_saturation();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
